// File: rtl/branch_hazard_unit_pkg.sv
// Shared pipeline definitions for the branch hazard unit: FSM states,
// operand-forward select encodings and stall-reason encodings.
package branch_hazard_unit_pkg;

    localparam int unsigned STALL_CNT_W = 8;
    localparam int unsigned PERF_W      = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        EX_WAIT  = 2'b01,
        MEM_WAIT = 2'b10
    } hz_state_e;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_ALU  = 2'b10;
    localparam logic [1:0] FWD_LOAD = 2'b01;

    localparam logic [1:0] REASON_NONE = 2'b00;
    localparam logic [1:0] REASON_EX   = 2'b01;
    localparam logic [1:0] REASON_MEM  = 2'b10;

    // Map the wait state to the externally visible stall reason.
    function automatic logic [1:0] state_reason(input hz_state_e s);
        logic [1:0] r;
        r = REASON_NONE;
        case (s)
            EX_WAIT:  r = REASON_EX;
            MEM_WAIT: r = REASON_MEM;
            default:  r = REASON_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_src_match.sv
// One branch source operand: liveness, EX-producer hit, pending MEM load,
// and the forward select this operand would use if the pipe is not stalled.
module branch_src_match
    import branch_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  branch,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic                  mem_mem_read,
    input  logic                  mem_ready,
    output logic                  ex_hit_c,
    output logic                  mem_pend_c,
    output logic [1:0]            fwd_sel_c
);

    logic live;
    logic mem_match;

    // Register 0 is hardwired, so it never creates a dependency.
    always_comb begin
        live       = branch & used & (rs != '0);
        mem_match  = live & mem_reg_write & (rs == mem_rd);
        ex_hit_c   = live & ex_reg_write & (rs == ex_rd);
        mem_pend_c = mem_match & mem_mem_read & ~mem_ready;
        fwd_sel_c  = FWD_RF;
        if (mem_match) begin
            fwd_sel_c = mem_mem_read ? FWD_LOAD : FWD_ALU;
        end
    end

endmodule

// File: rtl/branch_hazard_unit.sv
// Branch hazard unit: stalls an ID-stage branch whose sources are produced
// in EX or by a not-yet-ready MEM load, selects MEM forwarding otherwise,
// and flags stalls that run too long.
// Optional build macro: BRANCH_HAZARD_PERF_EN adds saturating perf counters.
module branch_hazard_unit
    import branch_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MAX_STALL  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_branch,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic                  mem_mem_read,
    input  logic                  mem_ready,
    input  logic                  flush,
    output logic [1:0]            fwd_sel_1,
    output logic [1:0]            fwd_sel_2,
    output logic                  stall,
    output logic [1:0]            stall_reason,
    output logic                  hazard_timeout
`ifdef BRANCH_HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0]     perf_stall_cycles,
    output logic [PERF_W-1:0]     perf_branches
`endif
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = STALL_CNT_W'(MAX_STALL);

    logic                   ex_hit_1, ex_hit_2;
    logic                   mem_pend_1, mem_pend_2;
    logic [1:0]             fsel_1, fsel_2;
    logic                   ex_hit, mem_pend;
    hz_state_e              state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    branch_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_src1 (
        .branch        (id_branch),
        .rs            (id_rs1),
        .used          (id_rs1_used),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_mem_read  (mem_mem_read),
        .mem_ready     (mem_ready),
        .ex_hit_c      (ex_hit_1),
        .mem_pend_c    (mem_pend_1),
        .fwd_sel_c     (fsel_1)
    );

    branch_src_match #(.REG_ADDR_W(REG_ADDR_W)) u_src2 (
        .branch        (id_branch),
        .rs            (id_rs2),
        .used          (id_rs2_used),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_mem_read  (mem_mem_read),
        .mem_ready     (mem_ready),
        .ex_hit_c      (ex_hit_2),
        .mem_pend_c    (mem_pend_2),
        .fwd_sel_c     (fsel_2)
    );

    // Same-cycle stall and forward selection; independent of FSM state so
    // back-to-back EX and MEM stalls chain without a gap.
    always_comb begin
        ex_hit    = ex_hit_1 | ex_hit_2;
        mem_pend  = mem_pend_1 | mem_pend_2;
        stall     = (ex_hit | mem_pend) & ~flush & ~reset;
        fwd_sel_1 = FWD_RF;
        fwd_sel_2 = FWD_RF;
        if (!stall && !reset) begin
            fwd_sel_1 = fsel_1;
            fwd_sel_2 = fsel_2;
        end
    end

    // Next-state: EX producer wins over a pending load; flush cancels both.
    always_comb begin
        state_d = IDLE;
        if (!flush) begin
            if (ex_hit) begin
                state_d = EX_WAIT;
            end else if (mem_pend) begin
                state_d = MEM_WAIT;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stall reason is a direct decode of the registered state.
    always_comb begin
        stall_reason = state_reason(state_q);
    end

    // Consecutive-stall counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q    <= '0;
            hazard_timeout <= 1'b0;
        end else if (stall) begin
            if (stall_cnt_q < CNT_MAX) begin
                stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
            end
            if (stall_cnt_q >= CNT_MAX - STALL_CNT_W'(1)) begin
                hazard_timeout <= 1'b1;
            end
        end else begin
            stall_cnt_q <= '0;
        end
    end

`ifdef BRANCH_HAZARD_PERF_EN
    // Saturating counters of stall cycles and branches that issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_branches     <= '0;
        end else begin
            if (stall && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + PERF_W'(1);
            end
            if (id_branch && !stall && !flush && (perf_branches != '1)) begin
                perf_branches <= perf_branches + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Self-checking bench for branch_hazard_unit: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_branch_hazard_unit;

    localparam int unsigned RW     = 5;
    localparam int unsigned MAXST  = 4;
    localparam int          NRAND  = 4000;

    logic          clk;
    logic          reset;
    logic          id_branch;
    logic [RW-1:0] id_rs1, id_rs2;
    logic          id_rs1_used, id_rs2_used;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_write;
    logic [RW-1:0] mem_rd;
    logic          mem_reg_write, mem_mem_read, mem_ready;
    logic          flush;
    logic [1:0]    fwd_sel_1, fwd_sel_2;
    logic          stall;
    logic [1:0]    stall_reason;
    logic          hazard_timeout;
`ifdef BRANCH_HAZARD_PERF_EN
    logic [31:0]   perf_stall_cycles, perf_branches;
`endif

    int checks = 0;
    int errors = 0;

    branch_hazard_unit #(.REG_ADDR_W(RW), .MAX_STALL(MAXST)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_branch      (id_branch),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_read   (mem_mem_read),
        .mem_ready      (mem_ready),
        .flush          (flush),
        .fwd_sel_1      (fwd_sel_1),
        .fwd_sel_2      (fwd_sel_2),
        .stall          (stall),
        .stall_reason   (stall_reason),
        .hazard_timeout (hazard_timeout)
`ifdef BRANCH_HAZARD_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_branches     (perf_branches)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0] m_reason;
    logic       m_timeout;
    int         m_run;
    logic       m_valid = 1'b0;
    longint     m_pstall, m_pbr;

    function automatic logic is_live(input logic br, input logic used, input logic [RW-1:0] rs);
        return br && used && (rs != 0);
    endfunction

    function automatic logic [1:0] want_fwd(input logic lv, input logic [RW-1:0] rs);
        if (lv && mem_reg_write && rs == mem_rd) return mem_mem_read ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    // Compare DUT to the model every cycle, then advance the model.
    always @(negedge clk) begin
        logic l1, l2, eh, mp, st;
        logic [1:0] f1, f2;
        l1 = is_live(id_branch, id_rs1_used, id_rs1);
        l2 = is_live(id_branch, id_rs2_used, id_rs2);
        eh = (l1 && ex_reg_write && id_rs1 == ex_rd) || (l2 && ex_reg_write && id_rs2 == ex_rd);
        mp = (l1 && mem_reg_write && mem_mem_read && !mem_ready && id_rs1 == mem_rd)
          || (l2 && mem_reg_write && mem_mem_read && !mem_ready && id_rs2 == mem_rd);
        st = (eh || mp) && !flush && !reset;
        f1 = (st || reset) ? 2'b00 : want_fwd(l1, id_rs1);
        f2 = (st || reset) ? 2'b00 : want_fwd(l2, id_rs2);
        chk("m_stall", 32'(stall), 32'(st));
        chk("m_fwd1", 32'(fwd_sel_1), 32'(f1));
        chk("m_fwd2", 32'(fwd_sel_2), 32'(f2));
        if (m_valid) begin
            chk("m_reason", 32'(stall_reason), 32'(m_reason));
            chk("m_timeout", 32'(hazard_timeout), 32'(m_timeout));
`ifdef BRANCH_HAZARD_PERF_EN
            chk("m_pstall", perf_stall_cycles, 32'(m_pstall));
            chk("m_pbr", perf_branches, 32'(m_pbr));
`endif
        end
        if (reset) begin
            m_reason  = 2'b00;
            m_timeout = 1'b0;
            m_run     = 0;
            m_pstall  = 0;
            m_pbr     = 0;
            m_valid   = 1'b1;
        end else begin
            m_reason = flush ? 2'b00 : (eh ? 2'b01 : (mp ? 2'b10 : 2'b00));
            m_run    = st ? m_run + 1 : 0;
            if (m_run >= int'(MAXST)) m_timeout = 1'b1;
            if (st) m_pstall++;
            if (id_branch && !st && !flush) m_pbr++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_in();
        id_branch = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_rd = 0; ex_reg_write = 0; mem_rd = 0; mem_reg_write = 0;
        mem_mem_read = 0; mem_ready = 1; flush = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex_hit();
        clear_in();
        id_branch = 1; id_rs1 = 5; id_rs1_used = 1; ex_rd = 5; ex_reg_write = 1;
    endtask

    task automatic set_load_wait(input logic ready);
        clear_in();
        id_branch = 1; id_rs2 = 4; id_rs2_used = 1;
        mem_rd = 4; mem_reg_write = 1; mem_mem_read = 1; mem_ready = ready;
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        repeat (2) next_cycle();
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_reason", 32'(stall_reason), 32'd0);
        chk("rst_timeout", 32'(hazard_timeout), 32'd0);
        chk("rst_fwd", 32'({fwd_sel_1, fwd_sel_2}), 32'd0);
        next_cycle();
        reset = 1'b0;

        // EX producer hit on rs1
        set_ex_hit();
        @(negedge clk);
        chk("ex_stall", 32'(stall), 32'd1);
        chk("ex_fwd", 32'({fwd_sel_1, fwd_sel_2}), 32'd0);
        next_cycle();
        clear_in();
        @(negedge clk);
        chk("ex_reason", 32'(stall_reason), 32'd1);
        chk("ex_release", 32'(stall), 32'd0);

        // MEM ALU forward on rs2 only
        next_cycle();
        clear_in();
        id_branch = 1; id_rs1 = 3; id_rs2 = 7; id_rs1_used = 1; id_rs2_used = 1;
        mem_rd = 7; mem_reg_write = 1; mem_mem_read = 0;
        @(negedge clk);
        chk("alu_stall", 32'(stall), 32'd0);
        chk("alu_fwd1", 32'(fwd_sel_1), 32'd0);
        chk("alu_fwd2", 32'(fwd_sel_2), 32'd2);

        // Load pending three cycles then data arrives
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            set_load_wait(1'b0);
            @(negedge clk);
            chk("ld_stall", 32'(stall), 32'd1);
        end
        next_cycle();
        set_load_wait(1'b1);
        @(negedge clk);
        chk("ld_reason", 32'(stall_reason), 32'd2);
        chk("ld_stall_rel", 32'(stall), 32'd0);
        chk("ld_fwd2", 32'(fwd_sel_2), 32'd1);

        // Register 0 never matches
        next_cycle();
        clear_in();
        id_branch = 1; id_rs1 = 0; id_rs1_used = 1; ex_rd = 0; ex_reg_write = 1;
        @(negedge clk);
        chk("r0_stall", 32'(stall), 32'd0);
        chk("r0_fwd", 32'({fwd_sel_1, fwd_sel_2}), 32'd0);

        // Flush overrides a hit and clears the stall run
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            set_ex_hit();
        end
        next_cycle();
        set_ex_hit();
        flush = 1;
        @(negedge clk);
        chk("fl_stall", 32'(stall), 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            set_ex_hit();
            if (i == 0) begin
                @(negedge clk);
                chk("fl_reason", 32'(stall_reason), 32'd0);
            end
        end
        next_cycle();
        clear_in();
        @(negedge clk);
        chk("fl_cnt_cleared", 32'(hazard_timeout), 32'd0);

        // Timeout after MAXST consecutive load stalls, sticky through flush
        for (int i = 1; i <= 6; i++) begin
            next_cycle();
            set_load_wait(1'b0);
            @(negedge clk);
            if (i == 4) chk("to_before", 32'(hazard_timeout), 32'd0);
            if (i == 5) chk("to_set", 32'(hazard_timeout), 32'd1);
        end
        next_cycle();
        set_load_wait(1'b1);
        @(negedge clk);
        chk("to_release", 32'(hazard_timeout), 32'd1);
        next_cycle();
        set_ex_hit();
        flush = 1;
        next_cycle();
        clear_in();
        @(negedge clk);
        chk("to_flush", 32'(hazard_timeout), 32'd1);

        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("to_reset", 32'(hazard_timeout), 32'd0);

        // Randomized traffic; sometimes hold inputs to build long stalls
        for (int n = 0; n < NRAND; n++) begin
            next_cycle();
            if ($urandom_range(0, 9) >= 3) begin
                id_branch     = ($urandom_range(0, 9) < 7);
                id_rs1        = RW'($urandom_range(0, 7));
                id_rs2        = RW'($urandom_range(0, 7));
                id_rs1_used   = ($urandom_range(0, 9) < 8);
                id_rs2_used   = ($urandom_range(0, 9) < 8);
                ex_rd         = RW'($urandom_range(0, 7));
                ex_reg_write  = 1'($urandom_range(0, 1));
                mem_rd        = RW'($urandom_range(0, 7));
                mem_reg_write = ($urandom_range(0, 9) < 6);
                mem_mem_read  = 1'($urandom_range(0, 1));
                mem_ready     = 1'($urandom_range(0, 1));
            end
            flush = ($urandom_range(0, 99) < 5);
            reset = ($urandom_range(0, 199) < 1);
        end
        next_cycle();
        reset = 1'b0;
        clear_in();
        repeat (2) next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
